tmc_timer_multi: RTL and testbench

TMC_TIMER_MULTI -- requirements
Module: tmc_timer_multi

---
 rtl/tmc_timer_pkg.sv | 20 ++
 rtl/tmc_timer_channel.sv | 128 ++++++++++++
 rtl/tmc_timer_multi.sv | 81 ++++++++
 tb/tb_tmc_timer_multi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmc_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map and CONTROL/STATUS bit positions.
package tmc_timer_pkg;

  localparam int REG_W = 3;

  localparam logic [REG_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [REG_W-1:0] REG_CONTROL  = 3'd1;
  localparam logic [REG_W-1:0] REG_PERIOD   = 3'd2;
  localparam logic [REG_W-1:0] REG_SNAP     = 3'd3;
  localparam logic [REG_W-1:0] REG_PRESCALE = 3'd4;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

endpackage

// File: rtl/tmc_timer_channel.sv
// One timer channel: prescaler, down-counter with reload, RUN/TO flags and its register bank.
module tmc_timer_channel
  import tmc_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter logic [31:0] RST_PERIOD = 32'd249999999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [REG_W-1:0] i_sel,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_pulse,
  output logic             o_irq
);

  localparam logic [CNT_W-1:0] RST_VAL = RST_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_prescale;
  logic             r_run;
  logic             r_to;
  logic             r_cont;
  logic             r_ito;
  logic             r_pulse;

  logic w_wr_status;
  logic w_wr_control;
  logic w_wr_period;
  logic w_wr_snap;
  logic w_wr_prescale;
  logic w_tick;
  logic w_timeout;

  assign w_wr_status   = i_we && (i_sel == REG_STATUS);
  assign w_wr_control  = i_we && (i_sel == REG_CONTROL);
  assign w_wr_period   = i_we && (i_sel == REG_PERIOD);
  assign w_wr_snap     = i_we && (i_sel == REG_SNAP);
  assign w_wr_prescale = i_we && (i_sel == REG_PRESCALE);

  assign w_tick    = r_run && (r_pre == r_prescale);
  assign w_timeout = w_tick && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= RST_VAL;
      r_period   <= RST_VAL;
      r_snap     <= '0;
      r_pre      <= '0;
      r_prescale <= '0;
      r_run      <= 1'b0;
      r_to       <= 1'b0;
      r_cont     <= 1'b0;
      r_ito      <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= w_timeout;

      if (w_wr_period || w_wr_prescale)
        r_pre <= '0;
      else if (w_tick)
        r_pre <= '0;
      else if (r_run)
        r_pre <= r_pre + PRE_W'(1);

      // A PERIOD write forces a reload even over a coincident tick.
      if (w_wr_period)
        r_cnt <= i_wdata[CNT_W-1:0];
      else if (w_timeout)
        r_cnt <= r_period;
      else if (w_tick)
        r_cnt <= r_cnt - CNT_W'(1);

      if (w_wr_period)
        r_run <= 1'b0;
      else if (w_wr_control && i_wdata[CTL_START])
        r_run <= 1'b1;
      else if (w_wr_control && i_wdata[CTL_STOP])
        r_run <= 1'b0;
      else if (w_timeout && !r_cont)
        r_run <= 1'b0;

      if (w_wr_status)
        r_to <= 1'b0;
      else if (w_timeout)
        r_to <= 1'b1;

      if (w_wr_control) begin
        r_cont <= i_wdata[CTL_CONT];
        r_ito  <= i_wdata[CTL_ITO];
      end

      if (w_wr_period)
        r_period <= i_wdata[CNT_W-1:0];
      if (w_wr_prescale)
        r_prescale <= i_wdata[PRE_W-1:0];
      if (w_wr_snap)
        r_snap <= r_cnt;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_sel)
      REG_STATUS: begin
        o_rdata[STS_RUN] = r_run;
        o_rdata[STS_TO]  = r_to;
      end
      REG_CONTROL: begin
        o_rdata[CTL_CONT] = r_cont;
        o_rdata[CTL_ITO]  = r_ito;
      end
      REG_PERIOD:   o_rdata = 32'(r_period);
      REG_SNAP:     o_rdata = 32'(r_snap);
      REG_PRESCALE: o_rdata = 32'(r_prescale);
      default:      o_rdata = '0;
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_irq   = r_to && r_ito;

endmodule

// File: rtl/tmc_timer_multi.sv
// Multi-channel timer with an Avalon-MM register interface; address is {channel, register}.
module tmc_timer_multi
  import tmc_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter logic [31:0] RST_PERIOD = 32'd249999999
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REG_W+$clog2(NUM_CH)-1:0] address,
  input  logic                             chipselect,
  input  logic                             write_n,
  input  logic [31:0]                      writedata,
  output logic [31:0]                      readdata,
  output logic [NUM_CH-1:0]                irq_vec,
  output logic                             irq,
  output logic [NUM_CH-1:0]                pulse_out
);

  localparam int AW   = REG_W + $clog2(NUM_CH);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]  w_ch;
  logic [REG_W-1:0] w_reg;
  logic             w_wr;
  logic [31:0]      w_ch_rdata [NUM_CH];
  logic [31:0]      w_rd;
  logic [31:0]      r_readdata;

  generate
    if (NUM_CH > 1) begin : g_ch_addr
      assign w_ch = address[AW-1:REG_W];
    end else begin : g_ch_zero
      assign w_ch = '0;
    end
  endgenerate

  assign w_reg = address[REG_W-1:0];
  assign w_wr  = chipselect && !write_n;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tmc_timer_channel #(
        .CNT_W      (CNT_W),
        .PRE_W      (PRE_W),
        .RST_PERIOD (RST_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr && (w_ch == CH_W'(i))),
        .i_sel   (w_reg),
        .i_wdata (writedata),
        .o_rdata (w_ch_rdata[i]),
        .o_pulse (pulse_out[i]),
        .o_irq   (irq_vec[i])
      );
    end
  endgenerate

  // Channel indices with no instance never match and so read as zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i))
        w_rd = w_ch_rdata[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_readdata <= '0;
    else
      r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_tmc_timer_multi.sv
// Bench for tmc_timer_multi: directed scenarios plus random register traffic against a behavioural model.
module tb_tmc_timer_multi;

  localparam logic [31:0] RST_P = 32'd249999999;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  irq_vec;
  logic        irq;
  logic [3:0]  pulse_out;

  tmc_timer_multi dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq),
    .pulse_out  (pulse_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  // model state
  logic [31:0] m_cnt [4];
  logic [31:0] m_period [4];
  logic [31:0] m_snap [4];
  logic [7:0]  m_pre [4];
  logic [7:0]  m_psc [4];
  logic [3:0]  m_run, m_to, m_cont, m_ito, m_pulse;
  logic [31:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = RST_P; m_period[i] = RST_P; m_snap[i] = 0;
      m_pre[i] = 0; m_psc[i] = 0;
    end
    m_run = 0; m_to = 0; m_cont = 0; m_ito = 0; m_pulse = 0; m_rd = 0;
  endtask

  // One rising edge of the behavioural model, using the inputs applied for that edge.
  task automatic model_step();
    int ch, sel;
    logic wr, we, run0, tick, tmo;
    logic [31:0] d;
    ch = int'(address[4:3]);
    sel = int'(address[2:0]);
    wr = chipselect && !write_n;
    d = writedata;
    case (sel)
      0: m_rd = {30'd0, m_run[ch], m_to[ch]};
      1: m_rd = {30'd0, m_cont[ch], m_ito[ch]};
      2: m_rd = m_period[ch];
      3: m_rd = m_snap[ch];
      4: m_rd = {24'd0, m_psc[ch]};
      default: m_rd = 0;
    endcase
    for (int i = 0; i < 4; i++) begin
      we = wr && (ch == i);
      run0 = m_run[i];
      tick = run0 && (m_pre[i] == m_psc[i]);
      tmo = tick && (m_cnt[i] == 0);
      m_pulse[i] = tmo;
      if (we && sel == 3) m_snap[i] = m_cnt[i];
      if (tmo) begin
        m_to[i] = 1'b1;
        if (!m_cont[i]) m_run[i] = 1'b0;
        m_cnt[i] = m_period[i];
      end else if (tick) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
      if (tick) m_pre[i] = 0;
      else if (run0) m_pre[i] = m_pre[i] + 1;
      if (we) begin
        case (sel)
          0: m_to[i] = 1'b0;
          1: begin
            m_cont[i] = d[1];
            m_ito[i] = d[0];
            if (d[2]) m_run[i] = 1'b1;
            else if (d[3]) m_run[i] = 1'b0;
          end
          2: begin
            m_period[i] = d; m_cnt[i] = d; m_pre[i] = 0; m_run[i] = 1'b0;
          end
          4: begin
            m_psc[i] = d[7:0]; m_pre[i] = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [4:0] a, input logic cs, input logic wn, input logic [31:0] d);
    address = a; chipselect = cs; write_n = wn; writedata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [4:0] a);
    drive(a, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 1'b1, 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("readdata", readdata, m_rd);
      chk("pulse_out", {28'd0, pulse_out}, {28'd0, m_pulse});
      chk("irq_vec", {28'd0, irq_vec}, {28'd0, m_to & m_ito});
      chk("irq", {31'd0, irq}, {31'd0, |(m_to & m_ito)});
    end
  end

  initial begin
    int first, np, sel;
    logic [4:0] a;
    reset = 1'b1; address = 0; chipselect = 0; write_n = 1; writedata = 0;
    model_reset();
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset values
    rd(5'd2);  chk("rst_ch0_period", readdata, 32'd249999999);
    rd(5'd0);  chk("rst_ch0_status", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // ch1 continuous, period 5, prescale 0
    wr(5'd10, 32'd5); wr(5'd12, 32'd0); wr(5'd9, 32'h7);
    first = -1; np = 0;
    for (int k = 1; k <= 30; k++) begin
      idle();
      if (pulse_out[1]) begin
        if (first < 0) first = k;
        np++;
      end
    end
    chk("ch1_first_pulse", first, 32'd6);
    chk("ch1_pulse_count", np, 32'd5);
    chk("ch1_irq_set", {31'd0, irq}, 32'd1);
    wr(5'd8, 32'd0);
    chk("ch1_irq_clear", {31'd0, irq}, 32'd0);
    wr(5'd9, 32'h8);

    // ch2 one-shot, period 3, prescale 2
    wr(5'd18, 32'd3); wr(5'd20, 32'd2); wr(5'd17, 32'h4);
    first = -1; np = 0;
    for (int k = 1; k <= 40; k++) begin
      idle();
      if (pulse_out[2]) begin
        if (first < 0) first = k;
        np++;
      end
    end
    chk("ch2_first_pulse", first, 32'd12);
    chk("ch2_pulse_count", np, 32'd1);
    rd(5'd16); chk("ch2_status", readdata, 32'd1);
    wr(5'd19, 32'd0); rd(5'd19); chk("ch2_reload", readdata, 32'd3);

    // ch0 snapshot and stop
    wr(5'd2, 32'd100); wr(5'd4, 32'd0); wr(5'd1, 32'h4);
    repeat (9) idle();
    wr(5'd3, 32'd0);
    rd(5'd3); chk("ch0_snap", readdata, 32'd91);
    rd(5'd3); chk("ch0_snap_stable", readdata, 32'd91);
    wr(5'd1, 32'h8);
    wr(5'd3, 32'd0);
    rd(5'd3); chk("ch0_stopped", readdata, 32'd87);
    repeat (20) idle();
    wr(5'd3, 32'd0);
    rd(5'd3); chk("ch0_frozen", readdata, 32'd87);
    rd(5'd0); chk("ch0_status_stop", readdata, 32'd0);

    // timeout coincident with STATUS write on ch3
    wr(5'd26, 32'd2); wr(5'd28, 32'd0); wr(5'd25, 32'h6);
    idle(); idle();
    wr(5'd24, 32'd0);
    chk("ch3_pulse", {31'd0, pulse_out[3]}, 32'd1);
    rd(5'd24); chk("ch3_to_cleared", readdata, 32'd2);
    wr(5'd25, 32'h8);

    // START and STOP together on ch2
    wr(5'd17, 32'hC);
    rd(5'd16); chk("ch2_start_wins", {31'd0, readdata[1]}, 32'd1);
    wr(5'd17, 32'h8);

    // random register traffic
    for (int k = 0; k < 3000; k++) begin
      a = 5'($urandom_range(0, 31));
      sel = int'(a[2:0]);
      if (sel == 2) writedata = $urandom_range(0, 12);
      else if (sel == 4) writedata = $urandom_range(0, 3);
      else if (sel == 1) writedata = $urandom_range(0, 15);
      else writedata = $urandom;
      drive(a, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), writedata);
    end

    // reset while ch3 counts
    wr(5'd26, 32'd4); wr(5'd28, 32'd0); wr(5'd25, 32'h6);
    repeat (7) idle();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_pulse", {28'd0, pulse_out}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_readdata", readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd(5'd26); chk("arst_ch3_period", readdata, 32'd249999999);
    rd(5'd24); chk("arst_ch3_status", readdata, 32'd0);
    rd(5'd25); chk("arst_ch3_control", readdata, 32'd0);
    rd(5'd28); chk("arst_ch3_prescale", readdata, 32'd0);
    rd(5'd27); chk("arst_ch3_snap", readdata, 32'd0);
    np = 0;
    for (int k = 0; k < 1000; k++) begin
      idle();
      if (pulse_out != 4'd0) np++;
    end
    chk("arst_no_pulse", np, 32'd0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
